iserdes_read_align: RTL and testbench
=====================================

// Module: iserdes_read_align
// PURPOSE
//  Read-side counterpart of the DDR3 output serializer path. Takes per-lane 4-sample parallel words
//  from an ISERDES in DDR 1:4 mode (clk_div domain). Applies a per-byte sample slip (0..3).
//  Waits a programmable read latency after each read command and assembles BL8 bursts.
//  Delivers one 8-sample-per-lane word per burst to the memory controller read path.
// PARAMETERS
//  WIDTH     8   DQ lanes handled (one byte lane group)
//  LAT_BITS  4   width of rd_lat; delay line depth 2**LAT_BITS
// PORTS
//  clk         in   1            clk_div-rate clock (ISERDES CLKDIV)
//  rst_n       in   1            synchronous reset, active low
//  din         in   4*WIDTH      ISERDES samples; din[4*i+k] = lane i, sample k (k=0 earliest)
//  rd_start    in   1            one-cycle pulse per BL8 read command
//  rd_lat      in   LAT_BITS     cycles from rd_start to first burst half
//  slip        in   2            manual sample slip (used when not training)
//  train       in   1            pulse: start slip training (MPR pattern reads follow)
//  dout        out  8*WIDTH      burst; dout[8*i+k] = lane i, sample k (k=0 earliest)
//  dout_valid  out  1            one-cycle strobe, dout valid
//  err         out  1            one-cycle strobe: burst dropped (collision)
//  slip_out    out  2            slip currently applied
//  train_done  out  1            one-cycle strobe: training finished
//  train_ok    out  1            level: last training found a match
// BEHAVIOUR
//  - Reset (rst_n=0 at clk edge): pend, hist, dout, dout_valid, err, train_done, train_ok, FSMs -> 0/IDLE.
//    slip_out = slip. Reset mid-burst discards all pending reads; no dout_valid is generated for them.
//  - hist <= din every cycle. Aligned window for slip s, per lane:
//    {hist[4-s..3], din[0..3-s]}. s=0 uses din only.
//  - Delay line pend[2**LAT_BITS-1:0] shifts toward bit 0 each cycle. rd_start in cycle t sets pend[rd_lat].
//    pend[0]=1 in cycle t+rd_lat+1.
//  - Capture FSM:
//    - IDLE: pend[0]=1 -> latch window as low half -> HALF2.
//    - HALF2: latch window as high half -> dout registered; dout_valid=1 in next cycle; -> IDLE.
//    - Latency: dout_valid in cycle t+rd_lat+3.
//  - Collisions:
//    - pend[0]=1 while in HALF2: the new burst is dropped and err pulses.
//    - rd_start when the target pend bit is already set: the new read is dropped and err pulses.
//    - Both in the same cycle: a single err pulse.
//    - rd_start every 2 cycles (tCCD) is sustained without error.
//  - dout holds its last value between strobes. slip changes take effect on the next window latch;
//    changing slip mid-burst is legal but corrupts that burst.
// CONFIGURATION
//  Macro READ_ALIGN_TRAIN_EN.
//  - Defined: training FSM T_IDLE/T_SEARCH/T_DONE.
//    - train -> T_SEARCH with trial slip 0, try count 0. slip_out = trial slip while in T_SEARCH/T_DONE.
//    - Each dout_valid is checked: lane0 byte == 8'h55 (MPR 0,1,0,1...).
//      - Match -> T_DONE: train_ok=1, train_done pulses.
//      - Mismatch -> trial slip+1; after 4 mismatches -> T_DONE: train_ok=0, train_done pulses, slip_out=0.
//    - T_DONE holds the trial slip until the next train. train in T_SEARCH restarts the search.
//  - Undefined: slip_out = slip always. train -> train_done pulses next cycle, train_ok=0.
// STRUCTURE
//  - Package ddr3_phy_pkg:
//    - SAMPLES_PER_CLK=4, BURST_LEN=8, MPR_PATTERN=8'h55
//    - capture state enum {CAP_IDLE, CAP_HALF2}
//    - train state enum {T_IDLE, T_SEARCH, T_DONE}
//  - Sub-module read_slip_lane (one per lane, generate loop): hist register + 4:1 window mux.
//  - Top holds the delay line, both FSMs and output registers.
// TESTING
//  1. rst_n=0 for 3 cycles with rd_start=1 -> dout_valid=0, err=0, dout=0, train_ok=0 for 3 cycles after release.
//  2. rd_lat=2, slip=0, rd_start@10; lane0 samples 1,0,1,1 @13 and 0,0,1,0 @14
//     -> dout_valid @15, dout[7:0]=8'h4D.
//  3. As 2 but slip=1, stream delayed one sample -> dout[7:0]=8'h4D @15.
//  4. rd_lat=0, rd_start @20 and @22 -> valids @23, @25, err=0.
//     rd_start @30 and @31 -> one valid @33, err=1 @32.
//  5. rd_start@10, rd_lat=3, rst_n=0 @14 for 1 cycle -> no dout_valid, err=0 through cycle 25.
//  6. READ_ALIGN_TRAIN_EN; train, then MPR reads with data offset by 2 samples
//     -> train_done after 3rd read, train_ok=1, slip_out=2.
//     All-zero data -> train_done after 4th read, train_ok=0, slip_out=0.

Source files
------------

// File: rtl/ddr3_phy_pkg.sv
// Shared definitions for the DDR3 PHY read path: burst geometry, MPR
// training pattern, FSM state encodings and the per-lane slip window helper.
package ddr3_phy_pkg;

  localparam int          SAMPLES_PER_CLK = 4;
  localparam int          BURST_LEN       = 8;
  localparam logic [7:0]  MPR_PATTERN     = 8'h55;

  typedef enum logic {
    CAP_IDLE,
    CAP_HALF2
  } cap_state_t;

  typedef enum logic [1:0] {
    T_IDLE,
    T_SEARCH,
    T_DONE
  } train_state_t;

  // Aligned 4-sample window for slip s: the last s samples of the previous
  // word followed by the first 4-s samples of the current word.
  function automatic logic [SAMPLES_PER_CLK-1:0] slip_window(
    input logic [SAMPLES_PER_CLK-1:0] hist,
    input logic [SAMPLES_PER_CLK-1:0] cur,
    input logic [1:0]                 s
  );
    logic [2*SAMPLES_PER_CLK-1:0] cat;
    cat = {cur, hist};
    case (s)
      2'd0:    slip_window = cur;
      2'd1:    slip_window = cat[6:3];
      2'd2:    slip_window = cat[5:2];
      default: slip_window = cat[4:1];
    endcase
  endfunction

endpackage

// File: rtl/read_slip_lane.sv
// One DQ lane of the read aligner: remembers the previous ISERDES word and
// presents the 4-sample window selected by the current slip.
module read_slip_lane
  import ddr3_phy_pkg::*;
(
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [SAMPLES_PER_CLK-1:0] din,
  input  logic [1:0]                 slip,
  output logic [SAMPLES_PER_CLK-1:0] window
);

  logic [SAMPLES_PER_CLK-1:0] hist;

  // Previous word, needed for the samples that straddle the word boundary.
  always_ff @(posedge clk) begin
    if (!rst_n) hist <= '0;
    else        hist <= din;
  end

  // Window mux.
  always_comb begin
    window = slip_window(hist, din, slip);
  end

endmodule

// File: rtl/iserdes_read_align.sv
// Read-side aligner: per-lane sample slip, read-latency delay line, BL8
// two-half capture and (optionally) MPR-based slip training.
// Optional feature macro: READ_ALIGN_TRAIN_EN enables the slip training FSM.
//
// Strobe semantics: there is no backpressure. dout_valid, err and train_done
// are single-cycle strobes; the consumer must take dout in the strobe cycle
// (dout also holds until the next strobe). rd_start and train are
// single-cycle request pulses that are always accepted or reported via err.
module iserdes_read_align
  import ddr3_phy_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int LAT_BITS = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [SAMPLES_PER_CLK*WIDTH-1:0] din,
  input  logic                          rd_start,
  input  logic [LAT_BITS-1:0]           rd_lat,
  input  logic [1:0]                    slip,
  input  logic                          train,
  output logic [BURST_LEN*WIDTH-1:0]    dout,
  output logic                          dout_valid,
  output logic                          err,
  output logic [1:0]                    slip_out,
  output logic                          train_done,
  output logic                          train_ok
);

  localparam int DEPTH = 2**LAT_BITS;

  logic [DEPTH-1:0]                     pend;
  logic [DEPTH-1:0]                     lat_onehot;
  logic                                 rd_drop;
  logic [SAMPLES_PER_CLK*WIDTH-1:0]     window;
  logic [SAMPLES_PER_CLK*WIDTH-1:0]     lo_q;
  logic [BURST_LEN*WIDTH-1:0]           burst;
  cap_state_t                           cap_state, cap_next;
  logic                                 latch_lo, latch_hi, cap_drop;

  // Per-lane slip windows; each burst byte is low half (older) then high half.
  for (genvar i = 0; i < WIDTH; i++) begin : g_lane
    read_slip_lane u_lane (
      .clk    (clk),
      .rst_n  (rst_n),
      .din    (din[SAMPLES_PER_CLK*i +: SAMPLES_PER_CLK]),
      .slip   (slip_out),
      .window (window[SAMPLES_PER_CLK*i +: SAMPLES_PER_CLK])
    );
    assign burst[BURST_LEN*i +: BURST_LEN] =
      {window[SAMPLES_PER_CLK*i +: SAMPLES_PER_CLK], lo_q[SAMPLES_PER_CLK*i +: SAMPLES_PER_CLK]};
  end

  // Delay-line insertion point; a read aimed at an occupied slot is dropped.
  always_comb begin
    lat_onehot         = '0;
    lat_onehot[rd_lat] = 1'b1;
    rd_drop            = rd_start && pend[rd_lat];
  end

  // Capture FSM state register.
  always_ff @(posedge clk) begin
    if (!rst_n) cap_state <= CAP_IDLE;
    else        cap_state <= cap_next;
  end

  // Capture FSM next state: a due read takes exactly two window latches.
  always_comb begin
    cap_next = cap_state;
    case (cap_state)
      CAP_IDLE:  if (pend[0]) cap_next = CAP_HALF2;
      CAP_HALF2: cap_next = CAP_IDLE;
    endcase
  end

  // Capture FSM outputs; a read falling due during the second half is lost.
  always_comb begin
    latch_lo = (cap_state == CAP_IDLE) && pend[0];
    latch_hi = (cap_state == CAP_HALF2);
    cap_drop = latch_hi && pend[0];
  end

  // Delay line, half-burst latch and output registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pend       <= '0;
      lo_q       <= '0;
      dout       <= '0;
      dout_valid <= 1'b0;
      err        <= 1'b0;
    end else begin
      pend       <= (pend >> 1) | ((rd_start && !rd_drop) ? lat_onehot : '0);
      if (latch_lo) lo_q <= window;
      if (latch_hi) dout <= burst;
      dout_valid <= latch_hi;
      err        <= cap_drop || rd_drop;
    end
  end

`ifdef READ_ALIGN_TRAIN_EN
  train_state_t t_state, t_next;
  logic [1:0]   trial;
  logic         mpr_hit;

  assign mpr_hit = (dout[7:0] == MPR_PATTERN);

  // Training state register plus trial slip and result flags.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      t_state    <= T_IDLE;
      trial      <= 2'd0;
      train_ok   <= 1'b0;
      train_done <= 1'b0;
    end else begin
      t_state    <= t_next;
      train_done <= 1'b0;
      if (train) begin
        trial <= 2'd0;
      end else if (t_state == T_SEARCH && dout_valid) begin
        if (mpr_hit) begin
          train_ok   <= 1'b1;
          train_done <= 1'b1;
        end else begin
          // Wraps 3 -> 0, which is the fallback slip after a failed search.
          trial <= trial + 2'd1;
          if (trial == 2'd3) begin
            train_ok   <= 1'b0;
            train_done <= 1'b1;
          end
        end
      end
    end
  end

  // Training next state: each returned burst is one trial.
  always_comb begin
    t_next = t_state;
    if (train) begin
      t_next = T_SEARCH;
    end else begin
      case (t_state)
        T_SEARCH: if (dout_valid && (mpr_hit || trial == 2'd3)) t_next = T_DONE;
        default:  t_next = t_state;
      endcase
    end
  end

  // Training outputs: the trial slip overrides the manual slip once trained.
  always_comb begin
    slip_out = (t_state == T_IDLE) ? slip : trial;
  end
`else
  // Training absent: acknowledge immediately, never report a match.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      train_done <= 1'b0;
      train_ok   <= 1'b0;
    end else begin
      train_done <= train;
      train_ok   <= 1'b0;
    end
  end

  // Manual slip only.
  always_comb begin
    slip_out = slip;
  end
`endif

endmodule

// File: tb/tb_iserdes_read_align.sv
// Directed bench for iserdes_read_align: reset, latency, slip windows,
// collisions, reset during a pending read and training behaviour.
module tb_iserdes_read_align;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] din;
  logic        rd_start;
  logic [3:0]  rd_lat;
  logic [1:0]  slip;
  logic        train;
  logic [63:0] dout;
  logic        dout_valid;
  logic        err;
  logic [1:0]  slip_out;
  logic        train_done;
  logic        train_ok;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  iserdes_read_align #(.WIDTH(8), .LAT_BITS(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .din        (din),
    .rd_start   (rd_start),
    .rd_lat     (rd_lat),
    .slip       (slip),
    .train      (train),
    .dout       (dout),
    .dout_valid (dout_valid),
    .err        (err),
    .slip_out   (slip_out),
    .train_done (train_done),
    .train_ok   (train_ok)
  );

  // Clock and watchdog.
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog cyc=%0d observed=timeout expected=finish", cyc);
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
    end
  endtask

  // Advance one cycle; pulse inputs and data return to idle.
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    rd_start = 1'b0;
    train    = 1'b0;
    din      = '0;
  endtask

  task automatic goto(input int n);
    while (cyc < n) tick();
  endtask

  // Reset for 3 cycles; cycle 0 is the first cycle with rst_n high.
  task automatic do_reset(input logic hold_start);
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      rd_start = hold_start;
      @(posedge clk);
      #1;
    end
    rst_n = 1'b1; rd_start = 1'b0; train = 1'b0; din = '0; cyc = 0;
  endtask

`ifdef READ_ALIGN_TRAIN_EN
  // One MPR read with rd_lat=1 issued at cycle t; lane0 words d0..d2 at t+1..t+3.
  task automatic mpr_read(input int t, input logic [3:0] d0, input logic [3:0] d1,
                          input logic [3:0] d2, input logic exp_done, input logic [1:0] exp_slip);
    goto(t);
    rd_lat = 4'd1; rd_start = 1'b1;
    tick(); din[3:0] = d0;
    tick(); din[3:0] = d1;
    tick(); din[3:0] = d2;
    tick(); check("mpr_valid", dout_valid, 1'b1);
    tick(); check("train_done", train_done, exp_done);
            check("train_slip", slip_out, exp_slip);
  endtask
`endif

  logic [3:0] slip_d12 [4];
  logic [3:0] slip_d13 [4];
  logic [3:0] slip_d14 [4];

  initial begin
    rst_n = 1'b0; din = '0; rd_start = 1'b0; rd_lat = '0; slip = 2'd1; train = 1'b0;

    // Reset with rd_start held high: nothing may come out afterwards.
    do_reset(1'b1);
    for (int c = 0; c < 3; c++) begin
      check("rst_valid", dout_valid, 1'b0);
      check("rst_err", err, 1'b0);
      check("rst_dout", dout, 64'h0);
      check("rst_train_ok", train_ok, 1'b0);
      check("rst_slip_out", slip_out, 2'd1);
      tick();
    end

    // Burst 1,0,1,1,0,0,1,0 on lane0 placed for each slip value.
    slip_d12[0] = 4'h0; slip_d13[0] = 4'hD; slip_d14[0] = 4'h4;
    slip_d12[1] = 4'h8; slip_d13[1] = 4'h6; slip_d14[1] = 4'h2;
    slip_d12[2] = 4'h4; slip_d13[2] = 4'h3; slip_d14[2] = 4'h1;
    slip_d12[3] = 4'hA; slip_d13[3] = 4'h9; slip_d14[3] = 4'h0;
    for (int s = 0; s < 4; s++) begin
      slip = s[1:0];
      do_reset(1'b0);
      goto(10);
      rd_lat = 4'd2; rd_start = 1'b1;
      goto(12); din[3:0] = slip_d12[s];
      tick();   din[3:0] = slip_d13[s]; din[7:4] = 4'h3;
      check("slip_out", slip_out, s[1:0]);
      tick();   din[3:0] = slip_d14[s]; din[7:4] = 4'hA;
      check("valid_early", dout_valid, 1'b0);
      tick();
      check("valid_at_lat", dout_valid, 1'b1);
      check("lane0_byte", dout[7:0], 8'h4D);
      if (s == 0) check("lane1_byte", dout[15:8], 8'hA3);
      tick();
      check("valid_one_shot", dout_valid, 1'b0);
      check("dout_hold", dout[7:0], 8'h4D);
    end

    // tCCD spacing sustained, then back-to-back collision.
    slip = 2'd0;
    do_reset(1'b0);
    rd_lat = 4'd0;
    goto(20); rd_start = 1'b1;
    for (int c = 21; c <= 35; c++) begin
      tick();
      if (c == 22 || c == 30 || c == 31) rd_start = 1'b1;
      check("ccd_valid", dout_valid, (c == 23 || c == 25 || c == 33));
      check("ccd_err", err, (c == 32));
    end

    // Reset while a read is pending discards it.
    do_reset(1'b0);
    rd_lat = 4'd3;
    goto(10); rd_start = 1'b1;
    for (int c = 11; c <= 25; c++) begin
      tick();
      rst_n = (c == 14) ? 1'b0 : 1'b1;
      check("rst_mid_valid", dout_valid, 1'b0);
      check("rst_mid_err", err, 1'b0);
    end
    rst_n = 1'b1;

`ifdef READ_ALIGN_TRAIN_EN
    // Pattern offset by two samples: slips 0 and 1 miss, slip 2 hits.
    slip = 2'd3;
    do_reset(1'b0);
    goto(2); train = 1'b1;
    tick();
    check("search_slip0", slip_out, 2'd0);
    mpr_read(10, 4'h4, 4'h5, 4'h1, 1'b0, 2'd1);
    mpr_read(20, 4'h4, 4'h5, 4'h1, 1'b0, 2'd2);
    mpr_read(30, 4'h4, 4'h5, 4'h1, 1'b1, 2'd2);
    check("train_ok_hit", train_ok, 1'b1);
    tick();
    check("done_one_shot", train_done, 1'b0);
    check("done_holds_slip", slip_out, 2'd2);
    // All-zero data: four misses, fall back to slip 0.
    goto(40); train = 1'b1;
    tick();
    check("restart_slip0", slip_out, 2'd0);
    mpr_read(50, 4'h0, 4'h0, 4'h0, 1'b0, 2'd1);
    mpr_read(60, 4'h0, 4'h0, 4'h0, 1'b0, 2'd2);
    mpr_read(70, 4'h0, 4'h0, 4'h0, 1'b0, 2'd3);
    check("ok_kept_in_search", train_ok, 1'b1);
    mpr_read(80, 4'h0, 4'h0, 4'h0, 1'b1, 2'd0);
    check("train_ok_miss", train_ok, 1'b0);
`else
    // No training hardware: immediate acknowledge, no match, manual slip.
    slip = 2'd2;
    do_reset(1'b0);
    goto(5); train = 1'b1;
    check("train_done_early", train_done, 1'b0);
    tick();
    check("train_done_ack", train_done, 1'b1);
    check("train_ok_zero", train_ok, 1'b0);
    check("train_slip_manual", slip_out, 2'd2);
    tick();
    check("train_done_one_shot", train_done, 1'b0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
